// File: rtl/mem_access_unit_if.sv
// Execute -> load/store stage request, data-memory bus and writeback bundle.
// 'slave' is the load/store unit; 'master' is everything around it (execute, memory, writeback).
interface mem_access_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_W   = 3
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic                  req_wide;
  logic [ADDR_W-1:0]     req_base;
  logic [ADDR_W-1:0]     req_off;
  logic [2*DATA_W-1:0]   req_wdata;
  logic [DATA_W-1:0]     req_alu;
  logic [RD_W-1:0]       req_rd;
  logic [ADDR_W-1:0]     dm_ea;
  logic [DATA_W-1:0]     dm_wdata;
  logic                  dm_mem_en;
  logic [DATA_W-1:0]     dm_rdata;
  logic                  wb_valid;
  logic                  wb_we;
  logic [RD_W-1:0]       wb_rd;
  logic [2*DATA_W-1:0]   wb_data;
  logic                  err;

  modport slave (
    input  req_valid, req_op, req_wide, req_base, req_off, req_wdata, req_alu, req_rd, dm_rdata,
    output req_ready, dm_ea, dm_wdata, dm_mem_en, wb_valid, wb_we, wb_rd, wb_data, err
  );

  modport master (
    output req_valid, req_op, req_wide, req_base, req_off, req_wdata, req_alu, req_rd, dm_rdata,
    input  req_ready, dm_ea, dm_wdata, dm_mem_en, wb_valid, wb_we, wb_rd, wb_data, err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store stage: one request at a time, one or two byte accesses to an
// async-read / negedge-write data memory, registered retire to writeback.
module mem_access_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_W   = 3
)(
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  localparam logic [1:0] OP_PASS  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1} state_t;

  typedef struct packed {
    logic [1:0]          op;
    logic                wide;
    logic [2*DATA_W-1:0] wdata;
    logic [DATA_W-1:0]   alu;
    logic [RD_W-1:0]     rd;
  } req_t;

  state_t            state;
  req_t              r;
  logic [ADDR_W-1:0] ea0;
  logic [DATA_W-1:0] lo;
  logic              mem_op, two_beat, last;

  assign mem_op   = (r.op == OP_LOAD) || (r.op == OP_STORE);
  assign two_beat = r.wide && mem_op;
  // Retire happens at the edge that closes the final access cycle.
  assign last     = (state == ACC1) || ((state == ACC0) && !two_beat);

  assign bus.req_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      r             <= '0;
      ea0           <= '0;
      lo            <= '0;
      bus.dm_ea     <= '0;
      bus.dm_wdata  <= '0;
      bus.dm_mem_en <= 1'b0;
      bus.wb_valid  <= 1'b0;
      bus.wb_we     <= 1'b0;
      bus.wb_rd     <= '0;
      bus.wb_data   <= '0;
      bus.err       <= 1'b0;
    end else begin
      // Bus and writeback outputs idle unless a cycle below drives them.
      bus.dm_ea     <= '0;
      bus.dm_wdata  <= '0;
      bus.dm_mem_en <= 1'b0;
      bus.wb_valid  <= 1'b0;
      bus.wb_we     <= 1'b0;
      bus.wb_rd     <= '0;
      bus.wb_data   <= '0;

      case (state)
        IDLE: if (bus.req_valid) begin
          r.op      <= bus.req_op;
          r.wide    <= bus.req_wide;
          r.wdata   <= bus.req_wdata;
          r.alu     <= bus.req_alu;
          r.rd      <= bus.req_rd;
          ea0       <= bus.req_base + bus.req_off;
          bus.dm_ea <= bus.req_base + bus.req_off;
          if (bus.req_op == OP_STORE) begin
            bus.dm_mem_en <= 1'b1;
            bus.dm_wdata  <= bus.req_wdata[DATA_W-1:0];
          end
          state <= ACC0;
        end
        ACC0: begin
          lo <= bus.dm_rdata;
          if (two_beat) begin
            bus.dm_ea <= ea0 + ADDR_W'(1);
            if (r.op == OP_STORE) begin
              bus.dm_mem_en <= 1'b1;
              bus.dm_wdata  <= r.wdata[2*DATA_W-1:DATA_W];
            end
            state <= ACC1;
          end else begin
            state <= IDLE;
          end
        end
        ACC1:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (last) begin
        bus.wb_valid <= 1'b1;
        bus.wb_rd    <= r.rd;
        case (r.op)
          OP_PASS: begin
            bus.wb_we   <= 1'b1;
            bus.wb_data <= {{DATA_W{1'b0}}, r.alu};
          end
          OP_LOAD: begin
            bus.wb_we   <= 1'b1;
            bus.wb_data <= r.wide ? {bus.dm_rdata, lo} : {{DATA_W{1'b0}}, bus.dm_rdata};
          end
          OP_STORE: ;
          default: bus.err <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural 256-byte data memory.
module tb_mem_access_unit;
  localparam int AW = 8, DW = 8, RW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(AW), .DATA_W(DW), .RD_W(RW)) bus();
  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .RD_W(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Data memory: async read, write on negedge; preloaded with i^0xA5.
  logic [7:0] mem [256];
  logic [7:0] exp_mem [256];
  bit         mem_init = 1'b0;
  assign bus.dm_rdata = mem[bus.dm_ea];
  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
      mem_init <= 1'b1;
    end else if (bus.dm_mem_en) begin
      mem[bus.dm_ea] <= bus.dm_wdata;
    end
  end

  typedef struct {
    logic [2:0]  rd;
    logic        we;
    logic [15:0] data;
    int          acc;
    int          lat;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0, n_bad = 0, cyc = 0, en_cnt = 0, idle_bad = 0;
  logic [7:0] en_ea, en_wd;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.dm_mem_en) begin
        en_cnt <= en_cnt + 1;
        en_ea  <= bus.dm_ea;
        en_wd  <= bus.dm_wdata;
      end
      if (bus.req_ready && (bus.dm_ea != '0 || bus.dm_mem_en)) idle_bad <= idle_bad + 1;
      if (bus.wb_valid) begin
        if (sb.size() == 0) chk("wb_unexpected", 32'(bus.wb_valid), 32'd0);
        else begin
          e = sb.pop_front();
          chk("wb_rd",      32'(bus.wb_rd),   32'(e.rd));
          chk("wb_we",      32'(bus.wb_we),   32'(e.we));
          chk("wb_data",    32'(bus.wb_data), 32'(e.data));
          chk("wb_latency", cyc - e.acc,      e.lat);
        end
      end
    end
  end

  // Drive one request, record expectation at the accepting edge.
  task automatic issue(input logic [1:0] op, input logic wide, input logic [7:0] base,
                       input logic [7:0] off, input logic [15:0] wdata, input logic [7:0] alu,
                       input logic [2:0] rd, input bit hold, output int acc);
    exp_t       e;
    logic [7:0] ea, ea1;
    @(negedge clk);
    bus.req_op = op; bus.req_wide = wide; bus.req_base = base; bus.req_off = off;
    bus.req_wdata = wdata; bus.req_alu = alu; bus.req_rd = rd; bus.req_valid = 1'b1;
    for (int n = 0; n < 20 && !bus.req_ready; n++) @(negedge clk);
    chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    if (!hold) bus.req_valid = 1'b0;
    ea  = base + off;
    ea1 = ea + 8'd1;
    e.rd = rd; e.acc = acc; e.we = 1'b0; e.data = 16'h0; e.lat = 1;
    case (op)
      2'b00: begin e.we = 1'b1; e.data = {8'h00, alu}; end
      2'b01: begin
        e.we   = 1'b1;
        e.lat  = wide ? 2 : 1;
        e.data = wide ? {exp_mem[ea1], exp_mem[ea]} : {8'h00, exp_mem[ea]};
      end
      2'b10: begin
        e.lat = wide ? 2 : 1;
        exp_mem[ea] = wdata[7:0];
        if (wide) exp_mem[ea1] = wdata[15:8];
      end
      default: ;
    endcase
    sb.push_back(e);
    @(negedge clk);
    chk("req_ready_acc0", 32'(bus.req_ready), 32'd0);
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
    chk("drain", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, a3, e0;
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_wide = 1'b0; bus.req_base = '0;
    bus.req_off = '0; bus.req_wdata = '0; bus.req_alu = '0; bus.req_rd = '0;
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'hA5;

    // Reset state
    @(negedge clk);
    chk("rst_ready",  32'(bus.req_ready), 32'd0);
    chk("rst_dm",     32'({bus.dm_ea, bus.dm_wdata, bus.dm_mem_en}), 32'd0);
    chk("rst_wb",     32'({bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data}), 32'd0);
    chk("rst_err",    32'(bus.err), 32'd0);
    #3 rst = 1'b0;

    // Narrow store 0x10+0x05, then load it back
    e0 = en_cnt;
    issue(2'b10, 1'b0, 8'h10, 8'h05, 16'h00AB, 8'h00, 3'd1, 1'b0, a0);
    drain();
    chk("st_en_pulses", en_cnt - e0, 32'd1);
    chk("st_ea", 32'(en_ea), 32'h15);
    chk("st_wd", 32'(en_wd), 32'hAB);
    issue(2'b01, 1'b0, 8'h15, 8'h00, 16'h0, 8'h00, 3'd3, 1'b0, a0);
    drain();

    // Wide store wrapping 0xFF -> 0x00, then wide load
    e0 = en_cnt;
    issue(2'b10, 1'b1, 8'hF0, 8'h0F, 16'hBEEF, 8'h00, 3'd2, 1'b0, a0);
    drain();
    chk("wst_en_pulses", en_cnt - e0, 32'd2);
    chk("wst_mem_ff", 32'(mem[8'hFF]), 32'hEF);
    chk("wst_mem_00", 32'(mem[8'h00]), 32'hBE);
    issue(2'b01, 1'b1, 8'hFF, 8'h00, 16'h0, 8'h00, 3'd5, 1'b0, a0);
    drain();

    // Pass-through (wide ignored), then illegal
    e0 = en_cnt;
    issue(2'b00, 1'b1, 8'h33, 8'h44, 16'hFFFF, 8'h5A, 3'd6, 1'b0, a0);
    drain();
    chk("pass_no_en", en_cnt - e0, 32'd0);
    chk("err_before", 32'(bus.err), 32'd0);
    issue(2'b11, 1'b1, 8'h01, 8'h02, 16'h1234, 8'h77, 3'd2, 1'b0, a0);
    drain();
    chk("err_set", 32'(bus.err), 32'd1);

    // Back-to-back narrow loads with req_valid held
    issue(2'b01, 1'b0, 8'h15, 8'h00, 16'h0, 8'h00, 3'd0, 1'b1, a0);
    issue(2'b01, 1'b0, 8'hFF, 8'h00, 16'h0, 8'h00, 3'd1, 1'b1, a1);
    issue(2'b01, 1'b0, 8'h00, 8'h00, 16'h0, 8'h00, 3'd2, 1'b1, a2);
    issue(2'b01, 1'b0, 8'h18, 8'h08, 16'h0, 8'h00, 3'd3, 1'b0, a3);
    drain();
    chk("b2b_gap1", a1 - a0, 32'd2);
    chk("b2b_gap2", a2 - a1, 32'd2);
    chk("b2b_gap3", a3 - a2, 32'd2);
    chk("err_sticky", 32'(bus.err), 32'd1);

    // Reset asserted during ACC1 of a wide store to 0x40
    issue(2'b10, 1'b1, 8'h3F, 8'h01, 16'h7788, 8'h00, 3'd4, 1'b0, a0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_dm",    32'({bus.dm_ea, bus.dm_wdata, bus.dm_mem_en}), 32'd0);
    chk("abort_wb",    32'({bus.wb_valid, bus.wb_we, bus.wb_data}), 32'd0);
    chk("abort_ready", 32'(bus.req_ready), 32'd0);
    sb.delete();
    exp_mem[8'h41] = 8'h41 ^ 8'hA5;
    repeat (2) @(negedge clk);
    chk("abort_mem_lo", 32'(mem[8'h40]), 32'h88);
    chk("abort_mem_hi", 32'(mem[8'h41]), 32'(8'h41 ^ 8'hA5));
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("post_rst_err",   32'(bus.err), 32'd0);
    issue(2'b01, 1'b1, 8'h40, 8'h00, 16'h0, 8'h00, 3'd7, 1'b0, a0);
    drain();
    chk("idle_bus_clean", idle_bad, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
